// File: rtl/svga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its video consumer.
// Latency: none, wires only.
// Backpressure: none; the raster is free-running, and the consumer only drives enable.
// Ports: enable (run request) and x_pos/y_pos, hsync/vsync/blank_z, end_line/end_frame,
//        frame_cnt, plus the delayed hsync_d/vsync_d/blank_z_d/comp_sync_d.
interface svga_timing_gen_if #(
    parameter int CW      = 12,
    parameter int FRAME_W = 8
);
    logic               enable;
    logic [CW-1:0]      x_pos;
    logic [CW-1:0]      y_pos;
    logic               hsync;
    logic               vsync;
    logic               blank_z;
    logic               end_line;
    logic               end_frame;
    logic [FRAME_W-1:0] frame_cnt;
    logic               hsync_d;
    logic               vsync_d;
    logic               blank_z_d;
    logic               comp_sync_d;

    // The generator side.
    modport master (
        input  enable,
        output x_pos, y_pos, hsync, vsync, blank_z, end_line, end_frame,
        output frame_cnt, hsync_d, vsync_d, blank_z_d, comp_sync_d
    );

    // The consumer side.
    modport slave (
        output enable,
        input  x_pos, y_pos, hsync, vsync, blank_z, end_line, end_frame,
        input  frame_cnt, hsync_d, vsync_d, blank_z_d, comp_sync_d
    );
endinterface

// File: rtl/svga_timing_gen.sv
// Parametrised SVGA raster timing generator: position, sync, blank, line/frame strobes.
// Latency: every output is registered, and enable affects them one clock later. The *_d copies
//          add a further PIPE_DELAY clocks.
// Backpressure: none; the raster advances every clock while enabled.
// Ports: clk (pixel clock), reset_n (async, ACTIVE-HIGH despite its name), and vid (interface,
//        master side) carrying enable in and all timing outputs.
// Option: define VGA_COMP_SYNC_EN to build the delayed active-low composite sync on
//         comp_sync_d. When it is undefined, comp_sync_d is tied to 1.
module svga_timing_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter int H_POL      = 1,
    parameter int V_POL      = 1,
    parameter int CW         = 12,
    parameter int PIPE_DELAY = 2,
    parameter int FRAME_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    svga_timing_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Thresholds are one bit wider than the counters. A sync end can then equal a total of 2^CW
    // without wrapping.
    localparam logic [CW:0] H_LAST = (CW+1)'(H_TOTAL - 1);
    localparam logic [CW:0] H_VIS  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] H_SS   = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] H_SE   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_LAST = (CW+1)'(V_TOTAL - 1);
    localparam logic [CW:0] V_VIS  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] V_SS   = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] V_SE   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic H_ON = (H_POL != 0);
    localparam logic V_ON = (V_POL != 0);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         state;
    logic [CW-1:0]      x_q, y_q;
    logic [CW-1:0]      nx, ny;
    logic               hsync_q, vsync_q, blank_q, eol_q, eof_q;
    logic [FRAME_W-1:0] frame_q;
    logic               nx_last, ny_last, h_act, v_act, vis;

    // Next position to present. Coming out of IDLE the raster must start at (0,0), not step
    // past it. That is why the step depends on the state rather than only on enable.
    always_comb begin
        nx = '0;
        ny = '0;
        if (state == ST_RUN) begin
            if ({1'b0, x_q} == H_LAST) begin
                ny = ({1'b0, y_q} == V_LAST) ? '0 : y_q + CW'(1);
            end else begin
                nx = x_q + CW'(1);
                ny = y_q;
            end
        end
    end

    // Decodes of the next position, so that the registered flags line up with x_pos/y_pos.
    assign nx_last = ({1'b0, nx} == H_LAST);
    assign ny_last = ({1'b0, ny} == V_LAST);
    assign h_act   = ({1'b0, nx} >= H_SS) && ({1'b0, nx} < H_SE);
    assign v_act   = ({1'b0, ny} >= V_SS) && ({1'b0, ny} < V_SE);
    assign vis     = ({1'b0, nx} < H_VIS) && ({1'b0, ny} < V_VIS);

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state   <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= ~H_ON;
            vsync_q <= ~V_ON;
            blank_q <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            // Counts a completed frame even when enable drops on this same edge.
            if (eof_q) begin
                frame_q <= frame_q + FRAME_W'(1);
            end
            if (vid.enable) begin
                state   <= ST_RUN;
                x_q     <= nx;
                y_q     <= ny;
                hsync_q <= h_act ? H_ON : ~H_ON;
                vsync_q <= v_act ? V_ON : ~V_ON;
                blank_q <= vis;
                eol_q   <= nx_last;
                eof_q   <= nx_last && ny_last;
            end else begin
                state   <= ST_IDLE;
                x_q     <= '0;
                y_q     <= '0;
                hsync_q <= ~H_ON;
                vsync_q <= ~V_ON;
                blank_q <= 1'b0;
                eol_q   <= 1'b0;
                eof_q   <= 1'b0;
            end
        end
    end

    assign vid.x_pos     = x_q;
    assign vid.y_pos     = y_q;
    assign vid.hsync     = hsync_q;
    assign vid.vsync     = vsync_q;
    assign vid.blank_z   = blank_q;
    assign vid.end_line  = eol_q;
    assign vid.end_frame = eof_q;
    assign vid.frame_cnt = frame_q;

`ifdef VGA_COMP_SYNC_EN
    // Active-low composite: low when exactly one of the two syncs is active.
    logic csync;
    assign csync = ~((hsync_q == H_ON) ^ (vsync_q == V_ON));
`endif

    // The delay line shifts every clock, in IDLE as well. After a stop it therefore drains
    // to the inactive levels.
    generate
        if (PIPE_DELAY == 0) begin : g_nodelay
            assign vid.hsync_d   = hsync_q;
            assign vid.vsync_d   = vsync_q;
            assign vid.blank_z_d = blank_q;
`ifdef VGA_COMP_SYNC_EN
            assign vid.comp_sync_d = csync;
`endif
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] h_pipe, v_pipe, b_pipe;
            always_ff @(posedge clk or posedge reset_n) begin
                if (reset_n) begin
                    h_pipe <= {PIPE_DELAY{~H_ON}};
                    v_pipe <= {PIPE_DELAY{~V_ON}};
                    b_pipe <= '0;
                end else begin
                    h_pipe <= (h_pipe << 1) | PIPE_DELAY'(hsync_q);
                    v_pipe <= (v_pipe << 1) | PIPE_DELAY'(vsync_q);
                    b_pipe <= (b_pipe << 1) | PIPE_DELAY'(blank_q);
                end
            end
            assign vid.hsync_d   = h_pipe[PIPE_DELAY-1];
            assign vid.vsync_d   = v_pipe[PIPE_DELAY-1];
            assign vid.blank_z_d = b_pipe[PIPE_DELAY-1];
`ifdef VGA_COMP_SYNC_EN
            logic [PIPE_DELAY-1:0] c_pipe;
            always_ff @(posedge clk or posedge reset_n) begin
                if (reset_n) begin
                    c_pipe <= '1;
                end else begin
                    c_pipe <= (c_pipe << 1) | PIPE_DELAY'(csync);
                end
            end
            assign vid.comp_sync_d = c_pipe[PIPE_DELAY-1];
`endif
        end
    endgenerate

`ifndef VGA_COMP_SYNC_EN
    assign vid.comp_sync_d = 1'b1;
`endif
endmodule

// File: tb/tb_svga_timing_gen.sv
module tb_svga_timing_gen;
    localparam int HT = 14;
    localparam int VT = 8;

    // Reset-value vectors laid out as {x,y,hsync,vsync,blank_z,end_line,end_frame,frame_cnt,
    // hsync_d,vsync_d,blank_z_d,comp_sync_d}.
    localparam logic [40:0] RST_P1 = {12'd0, 12'd0, 1'b0, 1'b0, 3'b000, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [40:0] RST_P0 = {12'd0, 12'd0, 1'b1, 1'b0, 3'b000, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    svga_timing_gen_if #(.CW(12), .FRAME_W(8)) ifa (), ifb (), ifc ();
    assign ifa.enable = enable;
    assign ifb.enable = enable;
    assign ifc.enable = enable;

    // a: nominal, b: PIPE_DELAY=0, c: H_POL=0
    svga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .H_POL(1), .V_POL(1), .CW(12), .PIPE_DELAY(2), .FRAME_W(8))
        dut_a (.clk(clk), .reset_n(reset_n), .vid(ifa));
    svga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .H_POL(1), .V_POL(1), .CW(12), .PIPE_DELAY(0), .FRAME_W(8))
        dut_b (.clk(clk), .reset_n(reset_n), .vid(ifb));
    svga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .H_POL(0), .V_POL(1), .CW(12), .PIPE_DELAY(2), .FRAME_W(8))
        dut_c (.clk(clk), .reset_n(reset_n), .vid(ifc));

    logic [40:0] act_a, act_b, act_c;
    assign act_a = {ifa.x_pos, ifa.y_pos, ifa.hsync, ifa.vsync, ifa.blank_z, ifa.end_line,
                    ifa.end_frame, ifa.frame_cnt, ifa.hsync_d, ifa.vsync_d, ifa.blank_z_d, ifa.comp_sync_d};
    assign act_b = {ifb.x_pos, ifb.y_pos, ifb.hsync, ifb.vsync, ifb.blank_z, ifb.end_line,
                    ifb.end_frame, ifb.frame_cnt, ifb.hsync_d, ifb.vsync_d, ifb.blank_z_d, ifb.comp_sync_d};
    assign act_c = {ifc.x_pos, ifc.y_pos, ifc.hsync, ifc.vsync, ifc.blank_z, ifc.end_line,
                    ifc.end_frame, ifc.frame_cnt, ifc.hsync_d, ifc.vsync_d, ifc.blank_z_d, ifc.comp_sync_d};

    // Reference model: m_t counts the clocks since the raster started. Position is plain
    // modular arithmetic on m_t. m_d1/m_d2 hold {hsync active, vsync active, visible} from
    // one and two clocks back.
    logic       m_run = 1'b0;
    int         m_t = 0;
    int         m_fc = 0;
    logic [2:0] m_d1 = 3'b000;
    logic [2:0] m_d2 = 3'b000;
    logic [40:0] m_now;

    function automatic logic [40:0] exp_vec(input logic hp, input int pd);
        int x, y;
        logic hs, vs, b, el, ef, dh, dv, db, cs;
        x  = m_run ? m_t % HT : 0;
        y  = m_run ? (m_t / HT) % VT : 0;
        hs = m_run && x >= 10 && x <= 12;
        vs = m_run && y >= 5 && y <= 6;
        b  = m_run && x < 8 && y < 4;
        el = m_run && x == HT - 1;
        ef = el && y == VT - 1;
        if (pd == 0) {dh, dv, db} = {hs, vs, b};
        else         {dh, dv, db} = m_d2;
`ifdef VGA_COMP_SYNC_EN
        cs = ~(dh ^ dv);
`else
        cs = 1'b1;
`endif
        return {12'(x), 12'(y), (hs ? hp : ~hp), vs, b, el, ef, 8'(m_fc),
                (dh ? hp : ~hp), dv, db, cs};
    endfunction

    always @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            m_run = 1'b0; m_t = 0; m_fc = 0; m_d1 = 3'b000; m_d2 = 3'b000;
        end else begin
            m_now = exp_vec(1'b1, 0);
            if (m_now[12]) m_fc = (m_fc + 1) % 256;       // end_frame presented
            m_d2 = m_d1;
            m_d1 = {m_now[16], m_now[15], m_now[14]};     // hsync, vsync, blank_z (pol 1)
            if (enable) begin
                m_t   = m_run ? m_t + 1 : 0;
                m_run = 1'b1;
            end else begin
                m_run = 1'b0;
                m_t   = 0;
            end
        end
    end

    task automatic test_reset();
        enable = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 3;
        if (act_a !== RST_P1) begin n_fail++; $display("FAIL reset_a: got %h want %h", act_a, RST_P1); end
        if (act_b !== RST_P1) begin n_fail++; $display("FAIL reset_b: got %h want %h", act_b, RST_P1); end
        if (act_c !== RST_P0) begin n_fail++; $display("FAIL reset_c: got %h want %h", act_c, RST_P0); end
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if (act_a !== RST_P1) begin n_fail++; $display("FAIL idle_a: got %h want %h", act_a, RST_P1); end
        if (act_c !== RST_P0) begin n_fail++; $display("FAIL idle_c: got %h want %h", act_c, RST_P0); end
    endtask

    task automatic test_first_line();
        enable = 1'b1;
        for (int i = 0; i < HT; i++) begin
            @(negedge clk);
            n_cmp += 7;
            if (act_a !== exp_vec(1'b1, 2)) begin n_fail++; $display("FAIL line_a i=%0d: got %h want %h", i, act_a, exp_vec(1'b1, 2)); end
            if (act_b !== exp_vec(1'b1, 0)) begin n_fail++; $display("FAIL line_b i=%0d: got %h want %h", i, act_b, exp_vec(1'b1, 0)); end
            if (act_c !== exp_vec(1'b0, 2)) begin n_fail++; $display("FAIL line_c i=%0d: got %h want %h", i, act_c, exp_vec(1'b0, 2)); end
            if (ifa.x_pos !== 12'(i) || ifa.y_pos !== 12'd0) begin n_fail++; $display("FAIL line_pos i=%0d: got x=%0d y=%0d", i, ifa.x_pos, ifa.y_pos); end
            if (ifa.blank_z !== (i < 8)) begin n_fail++; $display("FAIL line_blank i=%0d: got %b want %b", i, ifa.blank_z, (i < 8)); end
            if (ifa.hsync !== (i >= 10 && i <= 12) || ifc.hsync !== !(i >= 10 && i <= 12)) begin
                n_fail++; $display("FAIL line_hsync i=%0d: got a=%b c=%b", i, ifa.hsync, ifc.hsync);
            end
            if (ifa.end_line !== (i == HT - 1)) begin n_fail++; $display("FAIL line_eol i=%0d: got %b want %b", i, ifa.end_line, (i == HT - 1)); end
        end
    endtask

    task automatic test_frames();
        int efs[$];
        logic [7:0] fc0;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        fc0 = ifa.frame_cnt;
        for (int i = 0; i < 2 * HT * VT + 4; i++) begin
            @(negedge clk);
            n_cmp += 5;
            if (act_a !== exp_vec(1'b1, 2)) begin n_fail++; $display("FAIL frame_a i=%0d: got %h want %h", i, act_a, exp_vec(1'b1, 2)); end
            if (act_b !== exp_vec(1'b1, 0)) begin n_fail++; $display("FAIL frame_b i=%0d: got %h want %h", i, act_b, exp_vec(1'b1, 0)); end
            if (act_c !== exp_vec(1'b0, 2)) begin n_fail++; $display("FAIL frame_c i=%0d: got %h want %h", i, act_c, exp_vec(1'b0, 2)); end
            if (ifa.vsync !== (((i / HT) % VT) inside {5, 6})) begin n_fail++; $display("FAIL frame_vsync i=%0d: got %b", i, ifa.vsync); end
            if (ifa.frame_cnt !== 8'(int'(fc0) + efs.size())) begin
                n_fail++; $display("FAIL frame_cnt i=%0d: got %0d want %0d", i, ifa.frame_cnt, int'(fc0) + efs.size());
            end
            if (ifa.end_frame === 1'b1) efs.push_back(i);
        end
        n_cmp += 1;
        if (efs.size() != 2 || efs[0] != 111 || efs[1] != 223) begin
            n_fail++; $display("FAIL frame_strobes: got %0d pulses, want 2 at 111 and 223", efs.size());
        end
    endtask

    task automatic test_delay();
        logic [2:0] hist[$];
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            hist.push_back({ifa.hsync, ifa.vsync, ifa.blank_z});
            n_cmp += 1;
            if ({ifb.hsync_d, ifb.vsync_d, ifb.blank_z_d} !== {ifb.hsync, ifb.vsync, ifb.blank_z}) begin
                n_fail++; $display("FAIL delay0 i=%0d: got %b want %b", i, {ifb.hsync_d, ifb.vsync_d, ifb.blank_z_d}, {ifb.hsync, ifb.vsync, ifb.blank_z});
            end
            if (i >= 2) begin
                n_cmp += 1;
                if ({ifa.hsync_d, ifa.vsync_d, ifa.blank_z_d} !== hist[i - 2]) begin
                    n_fail++; $display("FAIL delay2 i=%0d: got %b want %b", i, {ifa.hsync_d, ifa.vsync_d, ifa.blank_z_d}, hist[i - 2]);
                end
            end
        end
    endtask

    task automatic test_drop_enable();
        logic [7:0] fc0;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 2 * HT + 6; i++) begin
            @(negedge clk);
            n_cmp += 1;
            if (act_a !== exp_vec(1'b1, 2)) begin n_fail++; $display("FAIL drop_run i=%0d: got %h want %h", i, act_a, exp_vec(1'b1, 2)); end
        end
        n_cmp += 1;
        if (ifa.x_pos !== 12'd5 || ifa.y_pos !== 12'd2) begin n_fail++; $display("FAIL drop_pos: got x=%0d y=%0d want 5,2", ifa.x_pos, ifa.y_pos); end
        fc0 = ifa.frame_cnt;
        enable = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if ({ifa.x_pos, ifa.y_pos, ifa.blank_z, ifa.hsync, ifa.frame_cnt} !== {24'd0, 1'b0, 1'b0, fc0}) begin
            n_fail++; $display("FAIL drop_idle: got x=%0d y=%0d b=%b h=%b fc=%0d want 0 0 0 0 %0d",
                               ifa.x_pos, ifa.y_pos, ifa.blank_z, ifa.hsync, ifa.frame_cnt, fc0);
        end
        if (act_c !== exp_vec(1'b0, 2)) begin n_fail++; $display("FAIL drop_c: got %h want %h", act_c, exp_vec(1'b0, 2)); end
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp += 1;
            if ({ifa.x_pos, ifa.y_pos, ifa.blank_z} !== {12'(i), 12'd0, 1'b1}) begin
                n_fail++; $display("FAIL restart i=%0d: got x=%0d y=%0d b=%b", i, ifa.x_pos, ifa.y_pos, ifa.blank_z);
            end
        end
    endtask

    task automatic test_comp_sync();
        logic want;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < HT * VT + 4; i++) begin
            @(negedge clk);
`ifdef VGA_COMP_SYNC_EN
            want = ~(ifa.hsync_d ^ ifa.vsync_d);
`else
            want = 1'b1;
`endif
            n_cmp += 1;
            if (ifa.comp_sync_d !== want) begin n_fail++; $display("FAIL comp_sync i=%0d: got %b want %b", i, ifa.comp_sync_d, want); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            n_cmp += 3;
            if (act_a !== exp_vec(1'b1, 2)) begin n_fail++; $display("FAIL rand_a i=%0d: got %h want %h", i, act_a, exp_vec(1'b1, 2)); end
            if (act_b !== exp_vec(1'b1, 0)) begin n_fail++; $display("FAIL rand_b i=%0d: got %h want %h", i, act_b, exp_vec(1'b1, 0)); end
            if (act_c !== exp_vec(1'b0, 2)) begin n_fail++; $display("FAIL rand_c i=%0d: got %h want %h", i, act_c, exp_vec(1'b0, 2)); end
            enable = ($urandom_range(0, 299) != 0);
        end
    endtask

    task automatic test_async_reset();
        enable = 1'b1;
        repeat ($urandom_range(20, 60)) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        n_cmp += 3;
        if (act_a !== RST_P1) begin n_fail++; $display("FAIL areset_a: got %h want %h", act_a, RST_P1); end
        if (act_b !== RST_P1) begin n_fail++; $display("FAIL areset_b: got %h want %h", act_b, RST_P1); end
        if (act_c !== RST_P0) begin n_fail++; $display("FAIL areset_c: got %h want %h", act_c, RST_P0); end
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_cmp += 2;
            if (act_a !== exp_vec(1'b1, 2)) begin n_fail++; $display("FAIL post_reset_a i=%0d: got %h want %h", i, act_a, exp_vec(1'b1, 2)); end
            if (act_c !== exp_vec(1'b0, 2)) begin n_fail++; $display("FAIL post_reset_c i=%0d: got %h want %h", i, act_c, exp_vec(1'b0, 2)); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_first_line();
        test_frames();
        test_delay();
        test_drop_enable();
        test_comp_sync();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end
endmodule
